// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: FSM state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the TX data field; the FSM lives in uart_tx_ctrl.
module uart_tx_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_next_bit,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    r_cnt;

  always_comb begin
    w_shift_nxt = r_shift;
    if (i_load)
      w_shift_nxt = i_data;
    else if (i_shift)
      w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
  end

  // Bit that will sit in position 0 next cycle; lets the owner register TX_OUT without extra latency.
  assign o_next_bit = w_shift_nxt[0];
  assign o_done     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      if (i_load || i_clr)
        r_cnt <= '0;
      else if (i_shift && !o_done)
        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start, LSB-first data, optional parity, stop; registered TX_OUT/Busy.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             par_bit,
  output logic             TX_OUT,
  output logic             Busy
);

  tx_state_e r_state;
  tx_state_e w_state_nxt;
  logic      r_par_en;
  logic      r_par_bit;
  logic      r_tx;
  logic      r_busy;
  logic      w_tx_nxt;
  logic      w_busy_nxt;
  logic      w_accept;
  logic      w_next_bit;
  logic      w_done;

  assign w_accept = Data_Valid && ((r_state == IDLE) || (r_state == STOP));

  uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_load     (w_accept),
    .i_clr      (r_state == START),
    .i_shift    (r_state == DATA),
    .i_data     (P_DATA),
    .o_next_bit (w_next_bit),
    .o_done     (w_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_tx      <= IDLE_LVL;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_accept) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= par_bit;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   w_state_nxt = DATA;
      DATA:    if (w_done) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY:  w_state_nxt = STOP;
      STOP:    w_state_nxt = w_accept ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line lines up with the state it belongs to.
  always_comb begin
    w_tx_nxt   = IDLE_LVL;
    w_busy_nxt = (w_state_nxt != IDLE);
    case (w_state_nxt)
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = w_next_bit;
      PARITY:  w_tx_nxt = (w_accept) ? par_bit : r_par_bit;
      STOP:    w_tx_nxt = STOP_BIT;
      default: w_tx_nxt = IDLE_LVL;
    endcase
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

  // Upstream parity must agree with the requested parity type.
  a_par_consistent: assert property (@(posedge CLK) disable iff (!RST)
    (w_accept && PAR_EN) |-> (par_bit == ((^P_DATA) ^ PAR_TYP)));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: driver pushes expected line bits, monitor pops while Busy.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       par_bit = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic exp_q[$];

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-written expected frames (start, LSB-first data, parity, stop).
  task automatic push_frame(input logic [10:0] bits, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(bits[i]);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [10:0] frame, input int len);
    @(posedge CLK) #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; par_bit = (^d) ^ pt; Data_Valid = 1'b1;
    @(posedge CLK);
    if (len > 0) push_frame(frame, len);
    #1 Data_Valid = 1'b0;
    P_DATA = $urandom; PAR_EN = $urandom; PAR_TYP = $urandom;
    par_bit = (^P_DATA) ^ PAR_TYP;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || Busy) && cyc < 40) begin
      @(negedge CLK); cyc++;
    end
    n_checks++;
    if (cyc >= 40) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bits still pending, busy=%b, required 0 and 0", name, exp_q.size(), Busy);
      exp_q.delete();
    end
  endtask

  always @(negedge CLK) begin
    if (RST && mon_en) begin
      if (Busy) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_busy: busy=1 with no frame pending, required busy=0 at %0t", $time);
        end else begin
          check("tx_bit", TX_OUT, exp_q.pop_front());
        end
      end else begin
        check("idle_tx", TX_OUT, 1'b1);
        if (exp_q.size() != 0) begin
          n_checks++; n_fail++;
          $display("FAIL busy_gap: busy=0 with %0d bits pending, required busy=1 at %0t", exp_q.size(), $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frames listed LSB = first bit on the line.
  localparam logic [10:0] F_A5_PAR  = 11'b10_1010_0101_0; // 0,1,0,1,0,0,1,0,1,0,1
  localparam logic [10:0] F_3C_NP   = 11'b0_1_0011_1100_0; // 0,0,0,1,1,1,1,0,0,1
  localparam logic [10:0] F_01_NP   = 11'b0_1_0000_0001_0; // 0,1,0,0,0,0,0,0,0,1
  localparam logic [10:0] F_00_ODD  = 11'b11_0000_0000_0; // 0, eight 0s, 1, 1

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", Busy, 1'b0);
    @(posedge CLK) #1 RST = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge CLK);

    send(8'hA5, 1'b1, 1'b0, F_A5_PAR, 11);
    wait_drain("parity_frame");
    repeat (3) @(posedge CLK);

    send(8'h3C, 1'b0, 1'b0, F_3C_NP, 10);
    wait_drain("noparity_frame");
    repeat (3) @(posedge CLK);

    // Pulse lands in DATA cycle 3 of the A5 frame and must be dropped.
    send(8'hA5, 1'b1, 1'b0, F_A5_PAR, 11);
    repeat (3) @(posedge CLK);
    send(8'hFF, 1'b0, 1'b0, 11'd0, 0);
    wait_drain("ignore_busy");
    repeat (14) @(posedge CLK);

    // Second request issued in the STOP cycle of the first frame.
    send(8'hA5, 1'b1, 1'b0, F_A5_PAR, 11);
    repeat (9) @(posedge CLK);
    check("stop_cycle_busy", Busy, 1'b1);
    send(8'h01, 1'b0, 1'b0, F_01_NP, 10);
    wait_drain("back_to_back");
    repeat (3) @(posedge CLK);

    // Reset in DATA bit 4 (line currently 0 for A5).
    send(8'hA5, 1'b1, 1'b0, F_A5_PAR, 11);
    repeat (5) @(posedge CLK);
    #2;
    check("pre_reset_tx", TX_OUT, 1'b0);
    RST = 1'b0;
    #1;
    check("async_reset_tx", TX_OUT, 1'b1);
    check("async_reset_busy", Busy, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (15) @(posedge CLK);
    #1 check("post_reset_idle_busy", Busy, 1'b0);

    send(8'h00, 1'b1, 1'b1, F_00_ODD, 11);
    wait_drain("odd_parity");
    repeat (5) @(posedge CLK);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d bits pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
